// File: rtl/instr_pkg.sv
// Shared instruction-format definitions for the instruction FIFO and the issue arbiter.
// Field positions are fixed by the instruction encoding.
package instr_pkg;

   localparam int INSTR_W      = 32;
   localparam int FIELD_ADRS_W = 9;
   localparam int DEF_DEPTH    = 8;

   localparam int OPC_MSB = 31;
   localparam int OPC_LSB = 29;
   localparam int OVR_MSB = 28;
   localparam int OVR_LSB = 27;
   localparam int SRC_MSB = 17;
   localparam int SRC_LSB = 9;
   localparam int DST_MSB = 8;
   localparam int DST_LSB = 0;

   // Bits 26:18 carry no field that matters to dependency tracking.
   typedef struct packed {
      logic [OPC_MSB-OPC_LSB:0] opc;
      logic [OVR_MSB-OVR_LSB:0] ovr;
      logic [OVR_LSB-SRC_MSB-2:0] rsvd;
      logic [SRC_MSB-SRC_LSB:0] src;
      logic [DST_MSB-DST_LSB:0] dst;
   } instr_t;

endpackage

// File: rtl/instr_dep_cmp.sv
// Hazard comparator for one queued entry against the arbiter's candidate addresses.
// Flags RAW, WAW and WAR overlaps; opcode and override bits play no part.
module instr_dep_cmp
   import instr_pkg::*;
#(
   parameter int WIDTH  = INSTR_W,
   parameter int ADRS_W = FIELD_ADRS_W
) (
   input  logic [WIDTH-1:0]  entry_i,
   input  logic              valid_i,
   input  logic [ADRS_W-1:0] query_src_i,
   input  logic [ADRS_W-1:0] query_dst_i,
   output logic              hit_o
);

   logic [ADRS_W-1:0] e_src;
   logic [ADRS_W-1:0] e_dst;
   logic              unused_fields;

   assign e_src = entry_i[SRC_LSB +: ADRS_W];
   assign e_dst = entry_i[DST_LSB +: ADRS_W];

   assign unused_fields = ^entry_i[WIDTH-1:SRC_LSB+ADRS_W];

   assign hit_o = valid_i & ((e_dst == query_src_i) |
                             (e_dst == query_dst_i) |
                             (e_src == query_dst_i));

endmodule

// File: rtl/instr_fifo.sv
// Per-lane instruction queue between the issue arbiter and the execute stage,
// first-word-fall-through, with a dependency lookup across all queued entries.
module instr_fifo
   import instr_pkg::*;
#(
   parameter int DEPTH  = DEF_DEPTH,     // power of two, 2 or more
   parameter int WIDTH  = INSTR_W,
   parameter int ADRS_W = FIELD_ADRS_W
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_instr,
   output logic                     full,
   input  logic                     pop,
   output logic [WIDTH-1:0]         pop_instr,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count,
   input  logic [ADRS_W-1:0]        query_src,
   input  logic [ADRS_W-1:0]        query_dst,
   output logic                     dep_hit,
   output logic                     overflow,
   output logic                     underflow
);

   localparam int PTR_W = $clog2(DEPTH);

   // Handshake: push is a request, !full (or full with a same-cycle accepted pop)
   // is its ready; pop is a request, !empty is its ready. Transfer happens on the
   // rising edge where both are high; a refused request only sets a sticky flag.

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W:0]   count_q, count_d;
   logic             overflow_q, overflow_d;
   logic             underflow_q, underflow_d;
   logic             pop_acc, push_acc;
   logic [DEPTH-1:0] hit;

   assign empty    = (count_q == '0);
   assign full     = (count_q == (PTR_W+1)'(DEPTH));
   assign pop_acc  = pop & ~empty;
   assign push_acc = push & (~full | pop_acc);

   always_comb begin
      rd_ptr_d    = rd_ptr_q;
      wr_ptr_d    = wr_ptr_q;
      count_d     = count_q;
      overflow_d  = overflow_q;
      underflow_d = underflow_q;
      if (pop_acc)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      if (push_acc) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (push_acc && !pop_acc)      count_d = count_q + (PTR_W+1)'(1);
      else if (pop_acc && !push_acc) count_d = count_q - (PTR_W+1)'(1);
      if (push && full && !pop_acc) overflow_d  = 1'b1;
      if (pop && empty)             underflow_d = 1'b1;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_ptr_q    <= '0;
         wr_ptr_q    <= '0;
         count_q     <= '0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         rd_ptr_q    <= rd_ptr_d;
         wr_ptr_q    <= wr_ptr_d;
         count_q     <= count_d;
         overflow_q  <= overflow_d;
         underflow_q <= underflow_d;
      end
   end

   // Storage is left unreset; count-derived valid bits mask stale contents.
   always_ff @(posedge clk) begin
      if (push_acc) mem_q[wr_ptr_q] <= push_instr;
   end

   assign pop_instr = empty ? '0 : mem_q[rd_ptr_q];
   assign count     = count_q;
   assign overflow  = overflow_q;
   assign underflow = underflow_q;

   for (genvar i = 0; i < DEPTH; i++) begin : g_dep
      logic [PTR_W-1:0] offs;
      logic             valid;
      assign offs  = PTR_W'(i) - rd_ptr_q;
      assign valid = ({1'b0, offs} < count_q);

      instr_dep_cmp #(
         .WIDTH  (WIDTH),
         .ADRS_W (ADRS_W)
      ) u_cmp (
         .entry_i     (mem_q[i]),
         .valid_i     (valid),
         .query_src_i (query_src),
         .query_dst_i (query_dst),
         .hit_o       (hit[i])
      );
   end

   assign dep_hit = |hit;

endmodule

// File: tb/tb_instr_fifo.sv
// Bench for instr_fifo: queue-based reference model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_instr_fifo;

   localparam int DEPTH = 8;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        push = 1'b0;
   logic        pop = 1'b0;
   logic [31:0] push_instr = '0;
   logic [8:0]  query_src = '0;
   logic [8:0]  query_dst = '0;
   logic        full, empty, dep_hit, overflow, underflow;
   logic [31:0] pop_instr;
   logic [3:0]  count;

   instr_fifo dut (
      .clk        (clk),
      .reset      (reset),
      .push       (push),
      .push_instr (push_instr),
      .full       (full),
      .pop        (pop),
      .pop_instr  (pop_instr),
      .empty      (empty),
      .count      (count),
      .query_src  (query_src),
      .query_dst  (query_dst),
      .dep_hit    (dep_hit),
      .overflow   (overflow),
      .underflow  (underflow)
   );

   always #5 clk = ~clk;

   // ---------------- scoreboard / reference model ----------------
   logic [31:0] exp_q[$];
   bit          m_ovf = 1'b0;
   bit          m_udf = 1'b0;
   int          n_checks = 0;
   int          n_errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic bit model_dep(input logic [8:0] qs, input logic [8:0] qd);
      foreach (exp_q[k]) begin
         if (exp_q[k][8:0] == qs || exp_q[k][8:0] == qd || exp_q[k][17:9] == qd) return 1'b1;
      end
      return 1'b0;
   endfunction

   always @(posedge reset) begin
      exp_q.delete();
      m_ovf = 1'b0;
      m_udf = 1'b0;
   end

   always @(posedge clk) begin : model
      bit pop_ok, push_ok;
      if (!reset) begin
         pop_ok  = pop && (exp_q.size() != 0);
         push_ok = push && ((exp_q.size() < DEPTH) || pop_ok);
         if (pop && exp_q.size() == 0) m_udf = 1'b1;
         if (push && exp_q.size() == DEPTH && !pop_ok) m_ovf = 1'b1;
         if (pop_ok) void'(exp_q.pop_front());
         if (push_ok) exp_q.push_back(push_instr);
      end
   end

   always @(negedge clk) begin
      chk("pop_instr", pop_instr, (exp_q.size() != 0) ? exp_q[0] : 32'h0);
      chk("empty", {31'b0, empty}, {31'b0, exp_q.size() == 0});
      chk("full", {31'b0, full}, {31'b0, exp_q.size() == DEPTH});
      chk("count", {28'b0, count}, exp_q.size());
      chk("dep_hit", {31'b0, dep_hit}, {31'b0, model_dep(query_src, query_dst)});
      chk("overflow", {31'b0, overflow}, {31'b0, m_ovf});
      chk("underflow", {31'b0, underflow}, {31'b0, m_udf});
   end

   // ---------------- driver tasks ----------------
   task automatic cycle(input bit p, input logic [31:0] d, input bit q);
      push = p;
      push_instr = d;
      pop = q;
      @(posedge clk);
      #1;
      push = 1'b0;
      pop = 1'b0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   // ---------------- stimulus ----------------
   logic [31:0] seq [20];
   logic [31:0] d;
   int          bias_push, bias_pop;

   initial begin
      #1 reset = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_empty", {31'b0, empty}, 32'h1);
      chk("rst_count", {28'b0, count}, 32'h0);
      chk("rst_full", {31'b0, full}, 32'h0);
      chk("rst_pop_instr", pop_instr, 32'h0);
      chk("rst_dep_hit", {31'b0, dep_hit}, 32'h0);
      chk("rst_flags", {30'b0, overflow, underflow}, 32'h0);
      reset = 1'b0;

      // in-order delivery
      cycle(1, 32'h0000_0101, 0);
      cycle(1, 32'h0000_0202, 0);
      cycle(1, 32'h0000_0303, 0);
      chk("fifo_count3", {28'b0, count}, 32'd3);
      chk("fifo_head0", pop_instr, 32'h0000_0101);
      cycle(0, 0, 1);
      chk("fifo_head1", pop_instr, 32'h0000_0202);
      cycle(0, 0, 1);
      chk("fifo_head2", pop_instr, 32'h0000_0303);
      cycle(0, 0, 1);
      chk("fifo_drained_empty", {31'b0, empty}, 32'h1);
      chk("fifo_drained_count", {28'b0, count}, 32'h0);

      // overflow drops the extra word
      do_reset();
      for (int i = 0; i < 8; i++) cycle(1, 32'h1000 + i, 0);
      cycle(1, 32'hDEAD_BEEF, 0);
      chk("ovf_full", {31'b0, full}, 32'h1);
      chk("ovf_flag", {31'b0, overflow}, 32'h1);
      chk("ovf_count", {28'b0, count}, 32'd8);
      for (int i = 0; i < 8; i++) begin
         chk("ovf_drain", pop_instr, 32'h1000 + i);
         cycle(0, 0, 1);
      end
      chk("ovf_after_drain_empty", {31'b0, empty}, 32'h1);

      // simultaneous push+pop while full, across pointer wrap
      do_reset();
      for (int i = 0; i < 20; i++) seq[i] = 32'hA000 + i;
      for (int i = 0; i < 8; i++) cycle(1, seq[i], 0);
      for (int k = 0; k < 12; k++) begin
         chk("wrap_head", pop_instr, seq[k]);
         cycle(1, seq[8+k], 1);
         chk("wrap_count", {28'b0, count}, 32'd8);
         chk("wrap_flags", {30'b0, overflow, underflow}, 32'h0);
      end
      for (int k = 0; k < 8; k++) begin
         chk("wrap_drain", pop_instr, seq[12+k]);
         cycle(0, 0, 1);
      end

      // dependency lookup
      do_reset();
      cycle(1, 32'hF800_0201, 0);
      query_src = 9'h001;
      query_dst = 9'h00F;
      #1 chk("dep_raw", {31'b0, dep_hit}, 32'h1);
      query_src = 9'h002;
      query_dst = 9'h002;
      #1 chk("dep_none", {31'b0, dep_hit}, 32'h0);
      query_src = 9'h001;
      query_dst = 9'h00F;
      cycle(0, 0, 1);
      chk("dep_after_pop", {31'b0, dep_hit}, 32'h0);
      query_src = 9'h000;
      query_dst = 9'h005;
      push = 1'b1;
      push_instr = 32'h0000_0A06;
      #1;
      chk("dep_no_bypass", {31'b0, dep_hit}, 32'h0);
      chk("data_no_bypass", pop_instr, 32'h0);
      @(posedge clk);
      #1;
      push = 1'b0;
      chk("dep_war", {31'b0, dep_hit}, 32'h1);
      chk("data_visible", pop_instr, 32'h0000_0A06);

      // underflow
      do_reset();
      cycle(0, 0, 1);
      chk("udf_pop_empty", {31'b0, underflow}, 32'h1);
      chk("udf_count0", {28'b0, count}, 32'h0);
      do_reset();
      cycle(1, 32'h0000_1234, 1);
      chk("udf_pushpop_flag", {31'b0, underflow}, 32'h1);
      chk("udf_pushpop_count", {28'b0, count}, 32'd1);
      chk("udf_pushpop_data", pop_instr, 32'h0000_1234);

      // asynchronous reset mid-cycle with entries queued
      do_reset();
      for (int i = 0; i < 5; i++) cycle(1, 32'h0000_3000 + i, 0);
      query_src = 9'h003;
      query_dst = 9'h1FF;
      #1 chk("arst_pre_dep", {31'b0, dep_hit}, 32'h1);
      #1 reset = 1'b1;
      #1;
      chk("arst_empty", {31'b0, empty}, 32'h1);
      chk("arst_count", {28'b0, count}, 32'h0);
      chk("arst_dep", {31'b0, dep_hit}, 32'h0);
      chk("arst_pop_instr", pop_instr, 32'h0);
      @(posedge clk);
      #1;
      reset = 1'b0;

      // randomized traffic, bias changes per phase to reach full and empty
      for (int ph = 0; ph < 6; ph++) begin
         bias_push = (ph % 2 == 0) ? 80 : 25;
         bias_pop  = (ph % 2 == 0) ? 30 : 75;
         for (int c = 0; c < 100; c++) begin
            d = $urandom;
            d[17:9] = 9'($urandom_range(0, 7));
            d[8:0]  = 9'($urandom_range(0, 7));
            query_src = 9'($urandom_range(0, 7));
            query_dst = 9'($urandom_range(0, 7));
            if ($urandom_range(0, 199) == 0) do_reset();
            else cycle($urandom_range(0, 99) < bias_push, d, $urandom_range(0, 99) < bias_pop);
         end
      end

      @(posedge clk);
      #1;
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/instr_fifo.md
INSTR_FIFO -- requirements
Module: instr_fifo

Interface
REQ-001 Parameter DEPTH, default 8: number of instruction entries; power of two, 2 or more.
REQ-002 Parameter WIDTH, default 32: instruction width in bits.
REQ-003 Parameter ADRS_W, default 9: width of the source and destination address fields.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 push  input  1  arbiter write request for this lane.
REQ-007 push_instr  input  WIDTH  instruction to enqueue.
REQ-008 full  output  1  high when count == DEPTH.
REQ-009 pop  input  1  execute-stage read request.
REQ-010 pop_instr  output  WIDTH  head instruction, first-word-fall-through.
REQ-011 empty  output  1  high when count == 0.
REQ-012 count  output  log2(DEPTH)+1  number of valid entries.
REQ-013 query_src  input  ADRS_W  source address of the candidate instruction at the arbiter.
REQ-014 query_dst  input  ADRS_W  destination address of the candidate instruction at the arbiter.
REQ-015 dep_hit  output  1  candidate depends on at least one queued entry.
REQ-016 overflow  output  1  sticky; set by a rejected push.
REQ-017 underflow  output  1  sticky; set by a rejected pop.

Function
REQ-018 Instruction fields are fixed: src = instr[17:9]; dst = instr[8:0]; override = instr[28:27]; opcode = instr[31:29].
REQ-019 A pop is accepted when pop=1 and empty=0; the head advances on that clock edge.
REQ-020 A push is accepted when push=1 and either full=0, or full=1 with a pop accepted in the same cycle.
REQ-021 An accepted push writes push_instr at the tail on the clock edge and the tail advances.
REQ-022 Read and write pointers are log2(DEPTH) bits wide and wrap from DEPTH-1 to 0 with no gap.
REQ-023 Count update: accepted push only, +1; accepted pop only, -1; both or neither, unchanged.
REQ-024 If push=1 and pop=1 while empty, the push is accepted, the pop is rejected, underflow is set, and count becomes 1.
REQ-025 If push=1 and pop=1 while full, both are accepted, count stays DEPTH, and overflow is not set.
REQ-026 pop_instr is combinational from the head entry; it is all-zero when empty.
REQ-027 Pushed data becomes visible on pop_instr in the cycle after the push edge; there is no bypass from push_instr.
REQ-028 dep_hit is combinational over the valid entries only; it is high if any valid entry satisfies e.dst == query_src (RAW), e.dst == query_dst (WAW) or e.src == query_dst (WAR).
REQ-029 dep_hit ignores the override field and the opcode field.
REQ-030 An entry popped on a clock edge no longer contributes to dep_hit after that edge; a pushed entry contributes starting after its push edge.
REQ-031 overflow is set on a cycle with push=1, full=1 and no accepted pop; the rejected data is dropped and the FIFO is unmodified.
REQ-032 underflow is set on any cycle with pop=1 and empty=1.
REQ-033 overflow and underflow are cleared only by reset.

Reset
REQ-034 Reset asserted clears both pointers and count to 0, with empty=1, full=0, pop_instr=0, dep_hit=0, overflow=0 and underflow=0, immediately and without waiting for clk.
REQ-035 Reset mid-operation discards all entries; entry storage need not be cleared because valid gating masks it.
REQ-036 The first accepted push is the first clock edge after reset deasserts.

Structure
REQ-037 Shared package instr_pkg holds the field bit positions (OPC, OVR, SRC, DST), ADRS_W, WIDTH and the default DEPTH, for reuse by the arbiter.
REQ-038 One sub-module, instr_dep_cmp, is instantiated per entry; it takes an entry, its valid bit, query_src and query_dst, and outputs a 1-bit hit; the hits are OR-reduced.

Verification
REQ-039 Reset, then push 0x0000_0101, 0x0000_0202, 0x0000_0303, then pop x3 -> pop_instr sequence 0x0000_0101, 0x0000_0202, 0x0000_0303, with empty=1 and count=0 at the end.
REQ-040 Push 8 entries, then a 9th (0xDEAD_BEEF) with pop=0 -> full=1, overflow=1, count=8, and 0xDEAD_BEEF is never popped.
REQ-041 Fill the FIFO, then hold push=1 and pop=1 for 12 cycles -> count stays 8, no flags set, and output order is preserved across pointer wrap.
REQ-042 Queue instr with src=0x001 and dst=0x001; query_src=0x001, query_dst=0x00F -> dep_hit=1; query_src=0x002, query_dst=0x002 -> dep_hit=0; after popping that entry, the first query -> dep_hit=0.
REQ-043 pop=1 while empty, and push+pop while empty -> underflow=1; in the second case count=1.
REQ-044 Assert reset asynchronously between clock edges with 5 entries queued -> empty=1, count=0 and dep_hit=0 before the next edge.
